// File: rtl/mux2_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_arbiter_if
//  Description : Handshake bundle for the 2-to-1 mux arbiter. Carries both
//                requester valid/data/ready channels, the registered output
//                channel and the mux select.
//                  master : requester/consumer side (drives valids, data,
//                           out_ready)
//                  slave  : arbiter side (drives readys, out_valid,
//                           out_data, sel)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux2_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, sel
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, sel
    );
endinterface
`default_nettype wire

// File: rtl/mux2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_arbiter
//  Description : Round-robin arbiter and sequencer for a 2-to-1 mux datapath.
//                Picks one of two valid/ready requesters per cycle, drives the
//                mux select and registers the winning beat into a one-entry
//                output stage with its own valid/ready handshake.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus(slave) - in0/in1 valid/data/ready, out valid/data/ready,
//                             sel (source of last accepted beat)
//  Parameters  : WIDTH      - data width
//                BURST_LEN  - max consecutive grants to one source (2..16),
//                             only used with MUX2_ARB_BURST_EN
//  Build macro : MUX2_ARB_BURST_EN - enables burst-mode arbitration
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_arbiter #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mux2_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;

    logic             w_load_en;
    logic             w_pick;     // winner when both requesters are valid
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;

    // Elaboration-time guard on the burst length range.
    if ((BURST_LEN < 2) || (BURST_LEN > 16)) begin : g_bad_burst_len
        $error("mux2_arbiter: BURST_LEN must be in 2..16");
    end

`ifdef MUX2_ARB_BURST_EN
    localparam int                 c_cnt_w   = $clog2(BURST_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BURST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    // Cleared by reset: until the first accept, sel is only a reset value,
    // so the first both-valid arbitration behaves as a source switch (in1).
    logic               r_primed;

    always_comb begin
        w_pick = ~r_sel;
        if (r_primed && (r_cnt < c_cnt_max)) begin
            w_pick = r_sel;
        end
    end
`else
    always_comb begin
        w_pick = ~r_sel;
    end
`endif

    // ------------------------------------------------------------------------
    // Grant logic. out_ready feeds the readys combinationally so a full
    // register can drain and refill in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_en = (r_state == ST_EMPTY) || bus.out_ready;
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        if (!rst && w_load_en) begin
            if (bus.in0_valid && bus.in1_valid) begin
                w_grant1 = w_pick;
                w_grant0 = ~w_pick;
            end else begin
                w_grant0 = bus.in0_valid;
                w_grant1 = bus.in1_valid;
            end
        end
        w_accept = w_grant0 | w_grant1;
    end

    // ------------------------------------------------------------------------
    // Output-register state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_accept && bus.out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_grant1 ? bus.in1_data : bus.in0_data;
            r_sel  <= w_grant1;
        end
    end

`ifdef MUX2_ARB_BURST_EN
    // Counts extra beats from the current source; saturates so a lone
    // requester can stream indefinitely without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (w_accept) begin
            r_primed <= 1'b1;
            if (r_primed && (w_grant1 == r_sel)) begin
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
`endif

    assign bus.in0_ready = w_grant0;
    assign bus.in1_ready = w_grant1;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_data;
    assign bus.sel       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux2_arbiter
//  Description : Self-checking bench for mux2_arbiter. Expected beats
//                ({sel, data}) are queued when a grant is expected and popped
//                when the output register should present them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [4:0] sb_q[$];
    logic [4:0] exp_beat;

    always #5 clk = ~clk;

    mux2_arbiter_if #(.WIDTH(4)) bus ();

    mux2_arbiter #(
        .WIDTH     (4),
        .BURST_LEN (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Drives one cycle of stimulus at the falling edge; readys are
    // combinational and valid 1 time unit later.
    task automatic drive(input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1,
                         input logic ordy, input logic r);
        @(negedge clk);
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
        rst           = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sb_pop();
        if (sb_q.size() == 0) return 5'h1F;
        return sb_q.pop_front();
    endfunction

    task automatic reset_pulse();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        sb_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b1);
            checks++;
            if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: in0_ready=%b in1_ready=%b expected 0 0",
                         i, bus.in0_ready, bus.in1_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.sel !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: valid=%b data=%h sel=%b expected 0 0 0",
                         i, bus.out_valid, bus.out_data, bus.sel);
            end
        end
        sb_q.delete();
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0);
        checks++;
        if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: in0_ready=%b in1_ready=%b expected 0 1",
                     bus.in0_ready, bus.in1_ready);
        end
        sb_q.push_back({1'b1, 4'h5});
        tick();
        exp_beat = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
            errors++;
            $display("FAIL first_beat: valid=%b data=%h sel=%b expected 1 %h %b",
                     bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0);
            checks++;
            if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_ready cyc%0d: in0_ready=%b in1_ready=%b expected 1 0",
                         i, bus.in0_ready, bus.in1_ready);
            end
            sb_q.push_back({1'b0, 4'h3});
            tick();
            exp_beat = sb_pop();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
                errors++;
                $display("FAIL single_out cyc%0d: valid=%b data=%h sel=%b expected 1 %h %b",
                         i, bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
            end
        end
    endtask

    task automatic test_alternation();
        logic exp_sel;
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            exp_sel = ((i % 2) == 0);
            drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0);
            checks++;
            if (bus.in1_ready !== exp_sel || bus.in0_ready !== !exp_sel) begin
                errors++;
                $display("FAIL alt_ready cyc%0d: in0_ready=%b in1_ready=%b expected %b %b",
                         i, bus.in0_ready, bus.in1_ready, !exp_sel, exp_sel);
            end
            sb_q.push_back({exp_sel, exp_sel ? 4'h5 : 4'hA});
            tick();
            exp_beat = sb_pop();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
                errors++;
                $display("FAIL alt_out cyc%0d: valid=%b data=%h sel=%b expected 1 %h %b",
                         i, bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
            end
        end
    endtask

    task automatic test_burst();
        logic [9:0] seq;
        logic       exp_sel;
        seq = 10'b1111000011;
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            exp_sel = seq[9-i];
            drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0);
            checks++;
            if (bus.in1_ready !== exp_sel || bus.in0_ready !== !exp_sel) begin
                errors++;
                $display("FAIL burst_ready cyc%0d: in0_ready=%b in1_ready=%b expected %b %b",
                         i, bus.in0_ready, bus.in1_ready, !exp_sel, exp_sel);
            end
            sb_q.push_back({exp_sel, exp_sel ? 4'h5 : 4'hA});
            tick();
            exp_beat = sb_pop();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
                errors++;
                $display("FAIL burst_out cyc%0d: valid=%b data=%h sel=%b expected 1 %h %b",
                         i, bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] held;
        logic       exp_sel;
        reset_pulse();
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0);
        sb_q.push_back({1'b1, 4'h5});
        tick();
        held = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held[3:0] || bus.sel !== held[4]) begin
            errors++;
            $display("FAIL bp_fill: valid=%b data=%h sel=%b expected 1 %h %b",
                     bus.out_valid, bus.out_data, bus.sel, held[3:0], held[4]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b0, 1'b0);
            checks++;
            if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready cyc%0d: in0_ready=%b in1_ready=%b expected 0 0",
                         i, bus.in0_ready, bus.in1_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held[3:0] || bus.sel !== held[4]) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h sel=%b expected 1 %h %b",
                         i, bus.out_valid, bus.out_data, bus.sel, held[3:0], held[4]);
            end
        end
`ifdef MUX2_ARB_BURST_EN
        exp_sel = 1'b1;   // still inside the first in1 burst
`else
        exp_sel = 1'b0;
`endif
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0);
        checks++;
        if (bus.in1_ready !== exp_sel || bus.in0_ready !== !exp_sel) begin
            errors++;
            $display("FAIL bp_release_ready: in0_ready=%b in1_ready=%b expected %b %b",
                     bus.in0_ready, bus.in1_ready, !exp_sel, exp_sel);
        end
        sb_q.push_back({exp_sel, exp_sel ? 4'h5 : 4'hA});
        tick();
        exp_beat = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
            errors++;
            $display("FAIL bp_release_out: valid=%b data=%h sel=%b expected 1 %h %b",
                     bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0);
        sb_q.push_back({1'b0, 4'hA});
        tick();
        exp_beat = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beat[3:0] || bus.sel !== exp_beat[4]) begin
            errors++;
            $display("FAIL rmid_fill: valid=%b data=%h sel=%b expected 1 %h %b",
                     bus.out_valid, bus.out_data, bus.sel, exp_beat[3:0], exp_beat[4]);
        end
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b1);
        checks++;
        if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ready: in0_ready=%b in1_ready=%b expected 0 0",
                     bus.in0_ready, bus.in1_ready);
        end
        sb_q.delete();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: valid=%b data=%h sel=%b expected 0 0 0",
                     bus.out_valid, bus.out_data, bus.sel);
        end
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty: valid=%b expected 0", bus.out_valid);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: size=%0d expected 0", sb_q.size());
        end
    endtask

    initial begin
        bus.in0_valid = 1'b0;
        bus.in0_data  = 4'h0;
        bus.in1_valid = 1'b0;
        bus.in1_data  = 4'h0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_single();
`ifdef MUX2_ARB_BURST_EN
        test_burst();
`else
        test_alternation();
`endif
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
